// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: runs one data-memory bus transaction per EX/MEM load or store and stalls the pipeline until it completes.
module mem_access_ctrl #(
  parameter int TIMEOUT    = 16,
  parameter bit CHECK_MASK = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [3:0]  MemRead_i,
  input  logic [3:0]  MemWrite_i,
  input  logic [31:0] ALUResult_i,
  input  logic [31:0] WriteData_i,
  input  logic        clr_fault_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic        mem_err_i,
  input  logic [31:0] mem_rdata_i,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic        rdata_valid_o,
  output logic        fault_o,
  output logic [31:0] fault_addr_o
);
  typedef enum logic [3:0] {IDLE = 4'b0001, BUSY = 4'b0010, DONE = 4'b0100, FAULT = 4'b1000} state_t;
  localparam logic [7:0] TO = 8'(TIMEOUT);
  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        we_q, we_d, rvalid_q, rvalid_d;
  logic [3:0]  be_q, be_d, mask;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d, faddr_q, faddr_d;
  logic        access, illegal;
  assign mask    = MemRead_i | MemWrite_i;
  assign access  = |mask;
  assign illegal = (|MemRead_i && |MemWrite_i) ||
                   (CHECK_MASK && !(mask inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111}));
  always_comb begin
    state_d  = state_q;
    cnt_d    = 8'd0;
    we_d     = we_q;
    be_d     = be_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    faddr_d  = faddr_q;
    case (state_q)
      IDLE: begin
        if (access && illegal) begin
          state_d = FAULT;
          faddr_d = ALUResult_i;
        end else if (access) begin
          state_d = BUSY;
          we_d    = |MemWrite_i;
          be_d    = mask;
          addr_d  = {ALUResult_i[31:2], 2'b00};
          wdata_d = WriteData_i;
        end
      end
      BUSY: begin
        cnt_d = cnt_q + 8'd1;
        // error beats ack; an ack on the timeout cycle still succeeds
        if (mem_err_i) begin
          state_d = FAULT;
          faddr_d = ALUResult_i;
        end else if (mem_ack_i) begin
          state_d  = DONE;
          cnt_d    = 8'd0;
          rdata_d  = we_q ? rdata_q : mem_rdata_i;
          rvalid_d = !we_q;
        end else if (cnt_d == TO) begin
          state_d = FAULT;
          faddr_d = ALUResult_i;
        end
      end
      DONE:    state_d = IDLE;
      FAULT:   state_d = clr_fault_i ? IDLE : FAULT;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      we_q     <= 1'b0;
      be_q     <= 4'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      rdata_q  <= 32'd0;
      rvalid_q <= 1'b0;
      faddr_q  <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      be_q     <= be_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      faddr_q  <= faddr_d;
    end
  end
  assign mem_req_o     = state_q == BUSY;
  assign done_o        = state_q == DONE;
  assign fault_o       = state_q == FAULT;
  assign mem_we_o      = we_q;
  assign mem_be_o      = be_q;
  assign mem_addr_o    = addr_q;
  assign mem_wdata_o   = wdata_q;
  assign rdata_o       = rdata_q;
  assign rdata_valid_o = rvalid_q;
  assign fault_addr_o  = faddr_q;
  // the IDLE stall is combinational, so it is gated to keep every output low during reset
  assign stall_o = !RST && ((state_q == IDLE) ? access : (state_q != DONE));
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: randomized scoreboard bench for mem_access_ctrl with a transaction-level outcome model.
module tb_mem_access_ctrl;
  localparam int T = 4;
  logic CLK = 1'b0, RST = 1'b1;
  logic [3:0] MemRead_i = '0, MemWrite_i = '0;
  logic [31:0] ALUResult_i = '0, WriteData_i = '0, mem_rdata_i = '0;
  logic clr_fault_i = 1'b0, mem_ack_i = 1'b0, mem_err_i = 1'b0;
  logic mem_req_o, mem_we_o, stall_o, done_o, rdata_valid_o, fault_o;
  logic [3:0] mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o, rdata_o, fault_addr_o;
  logic [3:0] n_rd = '0;
  logic [31:0] n_addr = '0, n_rdata = '0;
  logic n_ack = 1'b0;
  logic n_req, n_we, n_stall, n_done, n_rvalid, n_fault;
  logic [3:0] n_be;
  logic [31:0] n_maddr, n_wdata, n_rdo, n_faddr;

  mem_access_ctrl #(.TIMEOUT(T), .CHECK_MASK(1'b1)) dut (
    .CLK(CLK), .RST(RST), .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
    .ALUResult_i(ALUResult_i), .WriteData_i(WriteData_i), .clr_fault_i(clr_fault_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_err_i(mem_err_i), .mem_rdata_i(mem_rdata_i),
    .stall_o(stall_o), .done_o(done_o), .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o),
    .fault_o(fault_o), .fault_addr_o(fault_addr_o));

  mem_access_ctrl #(.TIMEOUT(T), .CHECK_MASK(1'b0)) u_nc (
    .CLK(CLK), .RST(RST), .MemRead_i(n_rd), .MemWrite_i(4'd0),
    .ALUResult_i(n_addr), .WriteData_i(32'd0), .clr_fault_i(1'b0),
    .mem_req_o(n_req), .mem_we_o(n_we), .mem_be_o(n_be), .mem_addr_o(n_maddr),
    .mem_wdata_o(n_wdata), .mem_ack_i(n_ack), .mem_err_i(1'b0), .mem_rdata_i(n_rdata),
    .stall_o(n_stall), .done_o(n_done), .rdata_o(n_rdo), .rdata_valid_o(n_rvalid),
    .fault_o(n_fault), .fault_addr_o(n_faddr));

  always #5 CLK = ~CLK;

  typedef struct {
    bit legal; bit is_fault; bit is_load; int t0; int lat;
    logic [31:0] rdata; logic [31:0] faddr; logic [31:0] addr;
    logic [3:0] be; logic we; logic [31:0] wdata;
  } exp_t;
  exp_t q[$];
  int tests = 0, errs = 0, cyc = 0;
  bit fault_seen = 1'b0;
  logic [31:0] last_rd = '0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // monitor: pops the scoreboard whenever the DUT completes or faults
  always @(negedge CLK) begin
    exp_t e;
    if (!RST) begin
      if (mem_req_o) begin
        if (q.size() == 0 || !q[0].legal) check("req_unexpected", 1, 0);
        else check("bus_fields", {mem_addr_o, mem_be_o, mem_we_o, mem_wdata_o},
                   {q[0].addr, q[0].be, q[0].we, q[0].wdata});
      end
      if (rdata_valid_o && !done_o) check("rvalid_without_done", 1, 0);
      if (done_o || (fault_o && !fault_seen)) begin
        if (q.size() == 0) check("unexpected_completion", {done_o, fault_o}, 0);
        else begin
          e = q.pop_front();
          check("outcome_fault", fault_o, e.is_fault);
          check("latency", cyc - e.t0, e.lat);
          if (done_o) begin
            check("rdata_valid", rdata_valid_o, e.is_load);
            check("rdata", rdata_o, e.rdata);
          end else check("fault_addr", fault_addr_o, e.faddr);
        end
      end
      fault_seen = fault_o;
    end
  end

  // kind: 0 ack, 1 err, 2 err+ack together, 3 no response; resp = BUSY cycle of the response
  task automatic txn(input logic [3:0] rd, input logic [3:0] wr, input logic [31:0] addr,
                     input logic [31:0] wd, input int kind, input int resp, input logic [31:0] rdv);
    exp_t e;
    logic [3:0] m;
    bit fin;
    m = rd | wr;
    e.legal = !(rd != 0 && wr != 0) && (m inside {4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF});
    e.t0 = cyc;
    e.addr = {addr[31:2], 2'b00};
    e.be = m;
    e.we = (wr != 0);
    e.wdata = wd;
    e.is_load = (rd != 0);
    e.faddr = addr;
    if (!e.legal) begin
      e.is_fault = 1; e.lat = 1;
    end else if (kind == 3 || resp > T) begin
      e.is_fault = 1; e.lat = T + 1;
    end else begin
      e.is_fault = (kind != 0); e.lat = resp + 1;
    end
    if (!e.is_fault && e.is_load) last_rd = rdv;
    e.rdata = last_rd;
    q.push_back(e);
    MemRead_i = rd; MemWrite_i = wr; ALUResult_i = addr; WriteData_i = wd;
    #1 check("stall_on_access", stall_o, 1);
    fin = 0;
    for (int j = 1; j <= T + 4; j++) begin
      @(negedge CLK);
      mem_ack_i = 0; mem_err_i = 0; mem_rdata_i = $urandom; clr_fault_i = 0;
      if (done_o || fault_o) begin fin = 1; break; end
      clr_fault_i = 1'($urandom_range(0, 1));
      if (e.legal && kind != 3 && j == resp) begin
        mem_ack_i = (kind != 1); mem_err_i = (kind != 0); mem_rdata_i = rdv;
      end
    end
    if (!fin) check("completion_timeout", 0, 1);
    if (fault_o) begin
      @(negedge CLK);
      check("fault_sticky", {fault_o, stall_o, mem_req_o}, 3'b110);
      clr_fault_i = 1;
      @(negedge CLK);
      clr_fault_i = 0;
      check("fault_cleared", {fault_o, stall_o}, 2'b01);
      MemRead_i = 0; MemWrite_i = 0;
      #1 check("idle_stall_follows", stall_o, 0);
    end else begin
      check("done_no_stall", stall_o, 0);
      MemRead_i = 0; MemWrite_i = 0;
    end
    @(negedge CLK);
    if ($urandom_range(0, 3) == 0) begin
      mem_ack_i = 1; mem_err_i = 1'($urandom_range(0, 1));
      @(negedge CLK);
      mem_ack_i = 0; mem_err_i = 0;
      check("spurious_ignored", {stall_o, done_o, fault_o, mem_req_o}, 0);
    end
  endtask

  initial begin
    exp_t e;
    logic [3:0] good [7] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF};
    logic [3:0] bad [8] = '{4'h5, 4'h6, 4'h9, 4'hA, 4'h7, 4'hB, 4'hD, 4'hE};
    logic [3:0] rd, wr;
    int r, kr, kind;
    repeat (3) @(negedge CLK);
    check("reset_ctrl", {mem_req_o, mem_we_o, mem_be_o, stall_o, done_o, rdata_valid_o, fault_o, mem_addr_o, mem_wdata_o}, 0);
    check("reset_data", {rdata_o, fault_addr_o}, 0);
    #2 RST = 0;
    @(negedge CLK);
    txn(4'hF, 4'h0, 32'h0000_1004, $urandom, 0, 1, 32'hDEAD_BEEF);
    txn(4'h0, 4'hC, 32'h0000_2002, 32'hABCD_0000, 0, 4, $urandom);
    txn(4'hF, 4'h0, 32'h0000_3008, $urandom, 3, 1, $urandom);
    txn(4'h5, 4'h0, 32'h0000_4000, $urandom, 0, 1, $urandom);
    txn(4'h1, 4'h1, 32'h0000_5001, $urandom, 0, 1, $urandom);
    txn(4'h3, 4'h0, 32'h0000_6002, $urandom, 2, 2, $urandom);
    txn(4'h1, 4'h0, 32'h0000_7003, $urandom, 0, T, 32'h1357_9BDF);
    txn(4'h0, 4'h8, 32'h0000_8003, $urandom, 1, 1, $urandom);
    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 9);
      rd = 0; wr = 0;
      if (r < 4) rd = good[$urandom_range(0, 6)];
      else if (r < 8) wr = good[$urandom_range(0, 6)];
      else if (r == 8) begin
        if ($urandom_range(0, 1) == 1) rd = bad[$urandom_range(0, 7)];
        else wr = bad[$urandom_range(0, 7)];
      end else begin
        rd = good[$urandom_range(0, 6)]; wr = good[$urandom_range(0, 6)];
      end
      kr = $urandom_range(0, 19);
      kind = kr < 14 ? 0 : kr < 17 ? 1 : kr < 18 ? 2 : 3;
      txn(rd, wr, $urandom, $urandom, kind, $urandom_range(1, 6), $urandom);
    end
    // unchecked-mask instance: 0101 is a normal load
    n_rd = 4'b0101; n_addr = 32'h0000_9006;
    #1 check("nc_stall", n_stall, 1);
    @(negedge CLK);
    check("nc_req", {n_req, n_we, n_be, n_maddr, n_fault}, {1'b1, 1'b0, 4'b0101, 32'h0000_9004, 1'b0});
    n_ack = 1; n_rdata = 32'h1234_5678;
    @(negedge CLK);
    n_ack = 0; n_rd = 0;
    check("nc_done", {n_done, n_rvalid, n_rdo, n_fault}, {1'b1, 1'b1, 32'h1234_5678, 1'b0});
    @(negedge CLK);
    // reset while waiting in BUSY
    e.legal = 1; e.is_fault = 0; e.is_load = 1; e.t0 = cyc; e.lat = 2; e.rdata = 0; e.faddr = 0;
    e.addr = 32'h0000_A000; e.be = 4'hF; e.we = 0; e.wdata = 32'h5555_AAAA;
    q.push_back(e);
    MemRead_i = 4'hF; ALUResult_i = 32'h0000_A000; WriteData_i = 32'h5555_AAAA;
    @(negedge CLK);
    check("busy_req", {mem_req_o, stall_o}, 2'b11);
    #2 RST = 1;
    #1 check("async_reset", {mem_req_o, stall_o, fault_o, done_o}, 0);
    check("reset_rdata", rdata_o, 0);
    q.delete();
    last_rd = 0;
    MemRead_i = 0;
    @(negedge CLK);
    #2 RST = 0;
    @(negedge CLK);
    check("idle_after_reset", {stall_o, mem_req_o, fault_o}, 0);
    txn(4'hF, 4'h0, 32'h0000_B000, $urandom, 0, 1, 32'hCAFE_F00D);
    repeat (3) @(negedge CLK);
    check("scoreboard_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
